// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the access-legality check used when a request is accepted.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } lsu_state_e;

  // Illegal width codes, unsigned stores, and misaligned half/word accesses.
  function automatic logic access_fault(input logic       store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_BU:   f = store;
      F3_H:    f = offset[0];
      F3_HU:   f = store | offset[0];
      F3_W:    f = (offset != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering between the word-wide memory bus and RV32I sub-word
// accesses: load extract/extend and store read-modify-write merge.
module lsu_data_align
  import load_store_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   offset_i,
  input  logic [N-1:0] rdata_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] load_o,
  output logic [N-1:0] merge_o
);

  logic [4:0]   shamt;
  logic [N-1:0] shifted;
  logic [N-1:0] lane_mask;
  logic [N-1:0] lane_data;

  assign shamt   = {offset_i, 3'b000};
  assign shifted = rdata_i >> shamt;

  // Load result: addressed byte/half moved to bit 0, then sign or zero extended.
  always_comb begin
    case (funct3_i)
      F3_B:    load_o = {{(N-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_o = {{(N-8){1'b0}}, shifted[7:0]};
      F3_H:    load_o = {{(N-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_o = {{(N-16){1'b0}}, shifted[15:0]};
      default: load_o = rdata_i;
    endcase
  end

  // Store merge: only the addressed lane(s) take store data, the rest keep the read word.
  always_comb begin
    case (funct3_i)
      F3_B: begin
        lane_mask = {{(N-8){1'b0}}, 8'hFF} << shamt;
        lane_data = {{(N-8){1'b0}}, wdata_i[7:0]} << shamt;
      end
      F3_H: begin
        lane_mask = {{(N-16){1'b0}}, 16'hFFFF} << shamt;
        lane_data = {{(N-16){1'b0}}, wdata_i[15:0]} << shamt;
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata_i;
      end
    endcase
  end

  assign merge_o = (rdata_i & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the word-only data memory bus. Executes one RV32I
// load/store per request; sub-word stores are read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int N         = 32,
  parameter int READ_WAIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_i,
  input  logic         store_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] store_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         fault_o,
  output logic [N-1:0] load_data_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_write_data_o,
  input  logic [N-1:0] mem_read_data_i
);

  if (READ_WAIT < 1) begin : g_bad_read_wait
    $error("load_store_unit: READ_WAIT must be at least 1");
  end

  localparam int            CW       = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_WAIT - 1);

  lsu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [N-1:0]  store_data_q;
  logic          fault_q;
  logic [N-1:0]  load_data_q;
  logic [N-1:0]  mem_addr_q;
  logic [N-1:0]  mem_wdata_q;

  logic [N-1:0]  align_load;
  logic [N-1:0]  align_merge;

  lsu_data_align #(.N(N)) u_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .rdata_i  (mem_read_data_i),
    .wdata_i  (store_data_q),
    .load_o   (align_load),
    .merge_o  (align_merge)
  );

  // Request latch, read-wait down-counter and sequencing FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      funct3_q     <= F3_B;
      off_q        <= 2'b00;
      store_data_q <= '0;
      fault_q      <= 1'b0;
      load_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            store_q      <= store_i;
            funct3_q     <= funct3_i;
            off_q        <= addr_i[1:0];
            store_data_q <= store_data_i;
            mem_addr_q   <= {addr_i[N-1:2], 2'b00};
            cnt_q        <= CNT_LOAD;
            if (access_fault(store_i, funct3_i, addr_i[1:0])) begin
              fault_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (store_i && (funct3_i == F3_W)) begin
              mem_wdata_q <= store_data_i;
              state_q     <= ST_WRITE;
            end else begin
              state_q <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == '0) begin
            if (store_q) begin
              mem_wdata_q <= align_merge;
              state_q     <= ST_WRITE;
            end else begin
              load_data_q <= align_load;
              state_q     <= ST_DONE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_WRITE: state_q <= ST_DONE;
        ST_DONE: begin
          fault_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign mem_we_o         = (state_q == ST_WRITE);
  assign fault_o          = fault_q;
  assign load_data_o      = load_data_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word memory (READ_WAIT=1).
module tb_load_store_unit;

  typedef struct {
    string       tag;
    logic        fault;
    int          lat;
    logic [31:0] ld;
    int          we_n;
    logic [31:0] wr;
    logic [31:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, fault, mem_we;
  logic [31:0] load_data, mem_addr, mem_write_data, mem_read_data;

  logic [31:0] mem [0:15];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat_cur = 0;
  int          we_cur = 0;
  int          we_total = 0;
  int          done_cnt = 0;
  logic [31:0] last_wr = '0;
  logic [31:0] model_ld = '0;

  always #5 clk = ~clk;

  load_store_unit #(.N(32), .READ_WAIT(1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .store_i          (store),
    .funct3_i         (funct3),
    .addr_i           (addr),
    .store_data_i     (store_data),
    .busy_o           (busy),
    .done_o           (done),
    .fault_o          (fault),
    .load_data_o      (load_data),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[5:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic exp_t mk(input string tag, input logic flt, input int lat,
                              input logic [31:0] ld, input int we_n,
                              input logic [31:0] wr, input logic [31:0] a);
    exp_t e;
    e.tag = tag; e.fault = flt; e.lat = lat; e.ld = ld;
    e.we_n = we_n; e.wr = wr; e.addr = a;
    return e;
  endfunction

  // Monitor: counts busy cycles and write pulses, pops the scoreboard on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_cur = 0;
        we_cur  = 0;
      end else begin
        if (busy) lat_cur++;
        else lat_cur = 0;
        if (mem_we) begin
          we_cur++;
          we_total++;
          last_wr = mem_write_data;
        end
        if (done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check({e.tag, "_fault"}, {31'd0, fault}, {31'd0, e.fault});
            check({e.tag, "_lat"}, 32'(lat_cur), 32'(e.lat));
            check({e.tag, "_ld"}, load_data, e.ld);
            check({e.tag, "_we_n"}, 32'(we_cur), 32'(e.we_n));
            check({e.tag, "_addr"}, mem_addr, e.addr);
            if (e.we_n != 0) check({e.tag, "_wr"}, last_wr, e.wr);
          end
          lat_cur = 0;
          we_cur  = 0;
        end
      end
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("idle_timeout", 32'(g), 32'd0);
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge clk);
    while (!done && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("done_timeout", 32'(g), 32'd0);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    store = st; funct3 = f3; addr = a; store_data = sd; req = 1'b1;
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input exp_t e);
    wait_idle();
    drive(st, f3, a, sd);
    sb.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
    wait_done();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check({pfx, "_done"}, {31'd0, done}, 32'd0);
    check({pfx, "_fault"}, {31'd0, fault}, 32'd0);
    check({pfx, "_load_data"}, load_data, 32'd0);
    check({pfx, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({pfx, "_mem_addr"}, mem_addr, 32'd0);
    check({pfx, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int d0;
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);
    preload(4'd1, 32'h8070_60F0);

    // Loads: extraction and extension per width and lane
    model_ld = 32'hFFFF_FFF0;
    run(0, 3'b000, 32'h0010_0004, 0, mk("lb_04", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'h0000_00F0;
    run(0, 3'b100, 32'h0010_0004, 0, mk("lbu_04", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'hFFFF_8070;
    run(0, 3'b001, 32'h0010_0006, 0, mk("lh_06", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'h0000_8070;
    run(0, 3'b101, 32'h0010_0006, 0, mk("lhu_06", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'hFFFF_FF80;
    run(0, 3'b000, 32'h0010_0007, 0, mk("lb_07", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'h0000_0060;
    run(0, 3'b100, 32'h0010_0005, 0, mk("lbu_05", 0, 2, model_ld, 0, 0, 32'h0010_0004));
    model_ld = 32'h8070_60F0;
    run(0, 3'b010, 32'h0010_0004, 0, mk("lw_04", 0, 2, model_ld, 0, 0, 32'h0010_0004));

    // Sub-word stores: read-modify-write, load_data untouched
    run(1, 3'b000, 32'h0010_0005, 32'h0000_00AB,
        mk("sb_05", 0, 3, model_ld, 1, 32'h8070_ABF0, 32'h0010_0004));
    preload(4'd1, 32'h8070_60F0);
    run(1, 3'b001, 32'h0010_0006, 32'h5555_1234,
        mk("sh_06", 0, 3, model_ld, 1, 32'h1234_60F0, 32'h0010_0004));
    preload(4'd1, 32'h8070_60F0);

    // Fault path: done in the first cycle, no bus writes
    run(1, 3'b010, 32'h0010_0002, 32'h1111_1111, mk("sw_02_flt", 1, 1, model_ld, 0, 0, 32'h0010_0000));
    run(0, 3'b001, 32'h0010_0005, 0, mk("lh_05_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(0, 3'b011, 32'h0010_0004, 0, mk("ld_011_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(0, 3'b110, 32'h0010_0004, 0, mk("ld_110_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(1, 3'b001, 32'h0010_0005, 32'h2222, mk("sh_05_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(1, 3'b010, 32'h0010_0005, 32'h3333, mk("sw_05_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(1, 3'b100, 32'h0010_0004, 32'h44, mk("st_100_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));
    run(1, 3'b111, 32'h0010_0004, 32'h55, mk("st_111_flt", 1, 1, model_ld, 0, 0, 32'h0010_0004));

    // Reset during the read phase of SH aborts before any write
    wait_idle();
    snap = we_total;
    drive(1, 3'b001, 32'h0010_0006, 32'h0000_5555);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("abort");
    req = 1'b0;
    repeat (2) @(posedge clk);
    check("abort_no_we", 32'(we_total), 32'(snap));
    @(negedge clk) rst_n = 1'b1;
    model_ld = 32'h8070_60F0;
    run(0, 3'b010, 32'h0010_0004, 0, mk("lw_after_rst", 0, 2, model_ld, 0, 0, 32'h0010_0004));

    // req held high chains SW then LW to the same word
    wait_idle();
    drive(1, 3'b010, 32'h0010_0008, 32'hDEAD_BEEF);
    sb.push_back(mk("chain_sw", 0, 2, model_ld, 1, 32'hDEAD_BEEF, 32'h0010_0008));
    @(posedge clk);
    #1 store = 1'b0;
    model_ld = 32'hDEAD_BEEF;
    sb.push_back(mk("chain_lw", 0, 2, model_ld, 0, 0, 32'h0010_0008));
    wait_done();
    @(posedge clk);
    @(posedge clk);
    #1 req = 1'b0;
    wait_done();

    // req toggled while busy must not start extra operations
    wait_idle();
    d0 = done_cnt;
    drive(1, 3'b000, 32'h0010_0009, 32'h0000_005A);
    sb.push_back(mk("toggle_sb", 0, 3, model_ld, 1, 32'hDEAD_5AEF, 32'h0010_0008));
    @(posedge clk);
    #1 req = 1'b0;
    funct3 = 3'b010;
    addr = 32'h0010_0008;
    store_data = 32'h1111_1111;
    #4 req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    #4 req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("toggle_done_pulses", 32'(done_cnt - d0), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
